// File: rtl/pixel_write_if.sv
// pixel_write_if
//   Bundles the plot-request handshake, the clear control/status and the
//   framebuffer write port of pixel_write_stage.
//   master : upstream/controller side (drives requests and clear_req,
//            observes ready, status and the framebuffer write port).
//   slave  : pixel_write_stage side.
//   Signals: in_valid/in_ready/in_x[7:0]/in_y[6:0]/in_col[2:0] plot request,
//            clear_req, busy, clear_done,
//            vga_x[7:0]/vga_y[6:0]/vga_col[2:0]/vga_plot framebuffer write.
interface pixel_write_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_col;
  logic       clear_req;
  logic       busy;
  logic       clear_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_col;
  logic       vga_plot;

  modport master (
    output in_valid, in_x, in_y, in_col, clear_req,
    input  in_ready, busy, clear_done, vga_x, vga_y, vga_col, vga_plot
  );

  modport slave (
    input  in_valid, in_x, in_y, in_col, clear_req,
    output in_ready, busy, clear_done, vga_x, vga_y, vga_col, vga_plot
  );
endinterface

// File: rtl/pixel_write_stage.sv
// pixel_write_stage
//   Buffered pixel-write stage between the circle controller and the VGA
//   framebuffer write port (160x120, 3-bit colour). Plot requests are
//   queued in a FIFO and written at most one per clock. On clear_req the
//   stage drains pending pixels, then sweeps the whole screen with
//   CLEAR_COLOR while still buffering new requests.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - pixel_write_if.slave (request handshake, clear control,
//            busy/clear_done status, registered framebuffer write port)
//   Optional feature: define PIXEL_WRITE_CLIP_EN to drop (accept without
//   pushing) requests with in_x > X_MAX or in_y > Y_MAX.
module pixel_write_stage #(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         X_MAX       = 159,
  parameter int         Y_MAX       = 119,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic         clk,
  input  logic         rst,
  pixel_write_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t      state, state_nxt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [17:0] mem [FIFO_DEPTH];
  logic [17:0] rd_data;
  logic        empty, full;
  logic        ready, accept, push, pop;
  logic [7:0]  cx;
  logic [6:0]  cy;
  logic        sweep_last;
  logic        sweep_end_p0;
  logic        clear_done_p1;
  logic [7:0]  vga_x_p0;
  logic [6:0]  vga_y_p0;
  logic [2:0]  vga_col_p0;
  logic        vga_plot_p0;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data    = mem[rd_ptr[AW-1:0]];
  assign sweep_last = (cx == 8'(X_MAX)) && (cy == 7'(Y_MAX));
  assign accept     = bus.in_valid && ready;

`ifdef PIXEL_WRITE_CLIP_EN
  // Off-screen requests complete the handshake but never reach the FIFO.
  assign push = accept && (bus.in_x <= 8'(X_MAX)) && (bus.in_y <= 7'(Y_MAX));
`else
  assign push = accept;
`endif

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    pop       = 1'b0;
    case (state)
      RUN: begin
        ready = !full;
        pop   = !empty;
        if (bus.clear_req) state_nxt = empty ? CLEAR : DRAIN;
      end
      DRAIN: begin
        pop = !empty;
        if (empty) state_nxt = CLEAR;
      end
      CLEAR: begin
        // Requests keep buffering during the sweep but nothing is popped,
        // so they land on screen after the clear.
        ready = !full;
        if (sweep_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cx            <= '0;
      cy            <= '0;
      sweep_end_p0  <= 1'b0;
      clear_done_p1 <= 1'b0;
      vga_x_p0      <= '0;
      vga_y_p0      <= '0;
      vga_col_p0    <= '0;
      vga_plot_p0   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};

      // Sweep raster: cx fastest; both wrap to 0 after the last pixel so
      // the next sweep starts at (0,0).
      if (state == CLEAR) begin
        if (cx == 8'(X_MAX)) begin
          cx <= '0;
          cy <= sweep_last ? 7'd0 : cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end

      // ---- stage p0: framebuffer write register ----
      if (pop) begin
        vga_x_p0    <= rd_data[17:10];
        vga_y_p0    <= rd_data[9:3];
        vga_col_p0  <= rd_data[2:0];
        vga_plot_p0 <= 1'b1;
      end else if (state == CLEAR) begin
        vga_x_p0    <= cx;
        vga_y_p0    <= cy;
        vga_col_p0  <= CLEAR_COLOR;
        vga_plot_p0 <= 1'b1;
      end else begin
        vga_plot_p0 <= 1'b0;
      end
      sweep_end_p0 <= (state == CLEAR) && sweep_last;

      // ---- stage p1: clear_done follows the last sweep write by a cycle ----
      clear_done_p1 <= sweep_end_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.in_x, bus.in_y, bus.in_col};
  end

  assign bus.in_ready   = ready;
  assign bus.busy       = (state != RUN) || !empty;
  assign bus.clear_done = clear_done_p1;
  assign bus.vga_x      = vga_x_p0;
  assign bus.vga_y      = vga_y_p0;
  assign bus.vga_col    = vga_col_p0;
  assign bus.vga_plot   = vga_plot_p0;

endmodule

// File: tb/tb_pixel_write_stage.sv
// tb_pixel_write_stage
//   Self-checking bench for pixel_write_stage. A monitor logs every
//   framebuffer write with its cycle number; each test task builds the
//   expected write list from the accepted requests and the screen raster
//   and compares.
module tb_pixel_write_stage;

  localparam int XM = 159;
  localparam int YM = 119;
  localparam int NPIX = (XM + 1) * (YM + 1);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    pix_t p;
    int   cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pixel_write_if bus ();

  pixel_write_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  wr_t  obs[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.vga_plot === 1'b1) obs.push_back('{p: pix_t'{bus.vga_x, bus.vga_y, bus.vga_col}, cyc: cyc});
    if (bus.clear_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  function automatic pix_t mk(input int x, input int y, input int c);
    mk = pix_t'{8'(x), 7'(y), 3'(c)};
  endfunction

  // Screen raster order of the clear sweep, background colour 0.
  function automatic pix_t sweep_pix(input int i);
    sweep_pix = mk(i % (XM + 1), i / (XM + 1), 0);
  endfunction

  function automatic bit on_screen(input pix_t p);
`ifdef PIXEL_WRITE_CLIP_EN
    on_screen = (int'(p.x) <= XM) && (int'(p.y) <= YM);
`else
    on_screen = 1'b1;
`endif
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.clear_req = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_col    = '0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      #1;
      if (!bus.busy && !bus.vga_plot) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.vga_x, bus.vga_y, bus.vga_col, bus.vga_plot, bus.clear_done} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d col=%0d plot=%0b done=%0b, expected all 0",
               bus.vga_x, bus.vga_y, bus.vga_col, bus.vga_plot, bus.clear_done);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b expected 0", bus.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    obs.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x = 8'd10;
    bus.in_y = 7'd20;
    bus.in_col = 3'b101;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %0b expected 1", bus.in_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({bus.busy, bus.vga_plot} !== 2'b10) begin
      errors++;
      $display("FAIL single_queued: got busy=%0b plot=%0b expected busy=1 plot=0", bus.busy, bus.vga_plot);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_col} !== {1'b1, 8'd10, 7'd20, 3'd5}) begin
      errors++;
      $display("FAIL single_write: got plot=%0b x=%0d y=%0d col=%0d expected plot=1 x=10 y=20 col=5",
               bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_col);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.vga_plot} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got busy=%0b plot=%0b expected 0 0", bus.busy, bus.vga_plot);
    end
  endtask

  task automatic test_random_stream();
    pix_t exp_p[$];
    int   exp_c[$];
    int   offered = 0, taken = 0, bad = 0;
    bit   ok;
    obs.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_x     = 8'($urandom_range(0, 170));
      bus.in_y     = 7'($urandom_range(0, 127));
      bus.in_col   = 3'($urandom);
      #1;
      if (bus.in_valid) offered++;
      if (bus.in_valid && bus.in_ready) begin
        taken++;
        if (on_screen(pix_t'{bus.in_x, bus.in_y, bus.in_col})) begin
          exp_p.push_back(pix_t'{bus.in_x, bus.in_y, bus.in_col});
          exp_c.push_back(cyc + 2);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stream_idle: busy did not clear within budget, expected idle");
    end
    checks++;
    if (taken != offered) begin
      errors++;
      $display("FAIL stream_no_stall: got %0d accepted expected %0d offered", taken, offered);
    end
    checks++;
    if (obs.size() != exp_p.size()) begin
      errors++;
      $display("FAIL stream_count: got %0d writes expected %0d", obs.size(), exp_p.size());
    end else begin
      for (int k = 0; k < exp_p.size(); k++)
        if (obs[k].p !== exp_p[k] || obs[k].cyc != exp_c[k]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL stream_data_latency: got %0d bad writes expected 0", bad);
      end
    end
  endtask

  task automatic test_drain_clear();
    pix_t pre[3];
    int   bad = 0, base, last;
    bit   ok;
    obs.delete();
    done_cnt = 0;
    for (int i = 0; i < 3; i++) pre[i] = mk($urandom_range(0, XM), $urandom_range(0, YM), $urandom_range(1, 7));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      {bus.in_x, bus.in_y, bus.in_col} = pre[i];
    end
    @(negedge clk);
    idle_inputs();
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_done_timeout: clear_done not seen, expected within 20000 cycles");
    end
    checks++;
    if (obs.size() != 3 + NPIX) begin
      errors++;
      $display("FAIL drain_count: got %0d writes expected %0d", obs.size(), 3 + NPIX);
    end else begin
      for (int i = 0; i < 3; i++) if (obs[i].p !== pre[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL drain_pixels_first: got %0d bad expected 0", bad);
      end
      bad = 0;
      for (int i = 0; i < NPIX; i++) if (obs[3 + i].p !== sweep_pix(i)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL drain_sweep_content: got %0d bad expected 0", bad);
      end
      base = 3;
      last = 3 + NPIX - 1;
      checks++;
      if (obs[base].p !== mk(0, 0, 0) || obs[last].p !== mk(XM, YM, 0)) begin
        errors++;
        $display("FAIL drain_sweep_ends: got first=%0h last=%0h expected %0h %0h",
                 obs[base].p, obs[last].p, mk(0, 0, 0), mk(XM, YM, 0));
      end
      checks++;
      if (obs[last].cyc - obs[base].cyc != NPIX - 1) begin
        errors++;
        $display("FAIL drain_sweep_consecutive: got span %0d expected %0d", obs[last].cyc - obs[base].cyc, NPIX - 1);
      end
      checks++;
      if (done_cyc != obs[last].cyc + 1) begin
        errors++;
        $display("FAIL drain_done_timing: got cycle %0d expected %0d", done_cyc, obs[last].cyc + 1);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL drain_done_pulses: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_clear_backpressure();
    pix_t req[12];
    int   k = 0, before_done = 0, c_clr, bad = 0;
    bit   ok;
    obs.delete();
    done_cnt = 0;
    for (int i = 0; i < 12; i++) req[i] = mk($urandom_range(0, XM), $urandom_range(0, YM), $urandom_range(0, 7));
    @(negedge clk);
    bus.clear_req = 1'b1;
    c_clr = cyc;
    for (int n = 0; n < 25000 && k < 12; n++) begin
      @(negedge clk);
      bus.clear_req = 1'b0;
      bus.in_valid = 1'b1;
      {bus.in_x, bus.in_y, bus.in_col} = req[k];
      #1;
      if (bus.in_ready) begin
        if (done_cnt == 0) before_done++;
        k++;
      end
    end
    @(negedge clk);
    idle_inputs();
    wait_idle(ok);
    checks++;
    if (k != 12 || !ok) begin
      errors++;
      $display("FAIL bp_complete: got %0d accepted idle=%0b expected 12 and idle", k, ok);
    end
    checks++;
    if (before_done != 8) begin
      errors++;
      $display("FAIL bp_accepts_during_clear: got %0d expected 8", before_done);
    end
    checks++;
    if (obs.size() != NPIX + 12) begin
      errors++;
      $display("FAIL bp_count: got %0d writes expected %0d", obs.size(), NPIX + 12);
    end else begin
      checks++;
      if (obs[0].cyc != c_clr + 2) begin
        errors++;
        $display("FAIL bp_first_sweep_latency: got cycle %0d expected %0d", obs[0].cyc, c_clr + 2);
      end
      for (int i = 0; i < NPIX; i++) if (obs[i].p !== sweep_pix(i)) bad++;
      for (int i = 0; i < 12; i++) if (obs[NPIX + i].p !== req[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL bp_order: got %0d bad writes expected 0", bad);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok = 1'b0;
    obs.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      #1;
      if (bus.vga_plot && bus.vga_x == 8'(5000 % (XM + 1)) && bus.vga_y == 7'(5000 / (XM + 1))) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midreset_reach_5000: sweep pixel 5000 not seen, expected within budget");
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.vga_x, bus.vga_y, bus.vga_col, bus.vga_plot, bus.clear_done, bus.busy, bus.in_ready} !== 22'd1) begin
      errors++;
      $display("FAIL midreset_outputs: got x=%0d y=%0d col=%0d plot=%0b busy=%0b ready=%0b expected 0s and ready=1",
               bus.vga_x, bus.vga_y, bus.vga_col, bus.vga_plot, bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    obs.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x = 8'd1;
    bus.in_y = 7'd1;
    bus.in_col = 3'd6;
    @(negedge clk);
    idle_inputs();
    repeat (40) @(negedge clk);
    checks++;
    if (obs.size() != 1 || obs[0].p !== mk(1, 1, 6)) begin
      errors++;
      $display("FAIL midreset_after: got %0d writes (first=%0h) expected 1 write %0h",
               obs.size(), (obs.size() > 0) ? obs[0].p : 18'h0, mk(1, 1, 6));
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d pulses expected 0", done_cnt);
    end
  endtask

  task automatic test_clip();
    pix_t a, b;
    pix_t exp_p[$];
    int   bad = 0;
    bit   ok;
    a = mk(160, 5, 3);
    b = mk(XM, YM, 4);
    if (on_screen(a)) exp_p.push_back(a);
    if (on_screen(b)) exp_p.push_back(b);
    obs.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    {bus.in_x, bus.in_y, bus.in_col} = a;
    @(negedge clk);
    {bus.in_x, bus.in_y, bus.in_col} = b;
    @(negedge clk);
    idle_inputs();
    wait_idle(ok);
    checks++;
    if (obs.size() != exp_p.size()) begin
      errors++;
      $display("FAIL clip_count: got %0d writes expected %0d", obs.size(), exp_p.size());
    end else begin
      for (int i = 0; i < exp_p.size(); i++) if (obs[i].p !== exp_p[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL clip_data: got %0d bad writes expected 0", bad);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_random_stream();
    test_drain_clear();
    test_clear_backpressure();
    test_reset_mid_sweep();
    test_clip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
